toggle_rx_deframer: RTL



---
 rtl/toggle_rx_deframer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/toggle_rx_deframer.sv
// toggle_rx_deframer
// Receive side of the toggle line code: a line toggle decodes to 1 and a held
// level decodes to 0. Hunts for SYNC_WORD, then assembles FRAME_BYTES LSB-first
// bytes and offers each through a one-entry valid/ready holding register.
// Optional build macro: TOGGLE_RX_DESTUFF_EN (drop the 0 stuffed after six
// consecutive 1s; a seventh 1 is a stuffing violation).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_HUNT | searching the decoded stream for SYNC_WORD
// ST_DATA | sync found, shifting in FRAME_BYTES data bytes
module toggle_rx_deframer #(
   parameter logic [7:0] SYNC_WORD   = 8'hA5,
   parameter int         FRAME_BYTES = 4
) (
   input  logic       clk,
   input  logic       areset_n,
   input  logic       line_in,
   input  logic       line_vld,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       locked,
   output logic       err_ovf,
   output logic       err_stuff
);

   typedef enum logic {
      ST_HUNT = 1'b0,
      ST_DATA = 1'b1
   } state_t;

   localparam logic [7:0] FRAME_LAST = 8'(FRAME_BYTES - 1);

   state_t     state;
   state_t     state_nxt;
   logic       prev_line;
   logic [7:0] sr;
   logic [2:0] bit_cnt;
   logic [7:0] byte_cnt;

   logic       dec_bit;
   logic [7:0] sr_shift;
   logic       bit_keep;
   logic       stuff_abort;
   logic       sync_hit;
   logic       byte_done;

   assign dec_bit  = line_in ^ prev_line;
   assign sr_shift = {dec_bit, sr[7:1]};

`ifdef TOGGLE_RX_DESTUFF_EN
   logic [2:0] ones_cnt;
   logic       stuff_drop;

   assign stuff_drop  = line_vld && (ones_cnt == 3'd6) && !dec_bit;
   assign stuff_abort = line_vld && (ones_cnt == 3'd6) && dec_bit;
   assign bit_keep    = line_vld && !stuff_drop && !stuff_abort;

   // run length of consecutive decoded 1s; a dropped or violating bit ends the run
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         ones_cnt <= 3'd0;
      end else if (stuff_drop || stuff_abort) begin
         ones_cnt <= 3'd0;
      end else if (line_vld) begin
         ones_cnt <= dec_bit ? ones_cnt + 3'd1 : 3'd0;
      end
   end

   // one-cycle violation pulse, the cycle after the offending sample
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         err_stuff <= 1'b0;
      end else begin
         err_stuff <= stuff_abort;
      end
   end
`else
   assign stuff_abort = 1'b0;
   assign bit_keep    = line_vld;
   assign err_stuff   = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state <= ST_HUNT;
      end else begin
         state <= state_nxt;
      end
   end

   // next state plus the sync / byte-complete strobes that drive the datapath
   always_comb begin
      state_nxt = state;
      sync_hit  = 1'b0;
      byte_done = 1'b0;
      if (stuff_abort) begin
         state_nxt = ST_HUNT;
      end else if (bit_keep) begin
         case (state)
            ST_HUNT: begin
               if (sr_shift == SYNC_WORD) begin
                  sync_hit  = 1'b1;
                  state_nxt = ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_cnt == 3'd7) begin
                  byte_done = 1'b1;
                  if (byte_cnt == FRAME_LAST) begin
                     state_nxt = ST_HUNT;
                  end
               end
            end
            default: state_nxt = ST_HUNT;
         endcase
      end
   end

   // line decode history and the shared sync/data shift register
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         prev_line <= 1'b0;
         sr        <= 8'd0;
      end else begin
         if (line_vld) begin
            prev_line <= line_in;
         end
         if (stuff_abort) begin
            sr <= 8'd0;
         end else if (bit_keep) begin
            sr <= sr_shift;
         end
      end
   end

   // bit and byte position within the frame; both restart on a sync match
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         bit_cnt  <= 3'd0;
         byte_cnt <= 8'd0;
      end else if (sync_hit) begin
         bit_cnt  <= 3'd0;
         byte_cnt <= 8'd0;
      end else if (bit_keep && (state == ST_DATA)) begin
         bit_cnt <= bit_cnt + 3'd1;
         if (byte_done) begin
            byte_cnt <= byte_cnt + 8'd1;
         end
      end
   end

   // one-entry holding register; a full register drops the new byte, not the old
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         rx_data  <= 8'd0;
         rx_valid <= 1'b0;
         err_ovf  <= 1'b0;
      end else begin
         err_ovf <= 1'b0;
         if (byte_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= sr_shift;
               rx_valid <= 1'b1;
            end else begin
               err_ovf <= 1'b1;
            end
         end else if (rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

   assign locked = (state == ST_DATA);

endmodule
